// File: rtl/power_ctrl.sv
// power_ctrl: debounced power-button FSM (OFF / ON / WAIT_REL) with long-press power-off.
// Optional two-sensor gesture on/off control is compiled in when GESTURE_CTRL_EN is defined.
module power_ctrl #(
    parameter int DEB_CYCLES  = 200000,
    parameter int LONG_CYCLES = 300000000,
    parameter int GEST_CYCLES = 500000000
) (
    input  logic clk,
    input  logic reset,
    input  logic power_btn,
    input  logic gest_l,
    input  logic gest_r,
    output logic power_on,
    output logic on_pulse,
    output logic off_pulse
);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_ON       = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    // Channel 0 is always the power button; channels 1/2 are gest_l/gest_r when enabled.
`ifdef GESTURE_CTRL_EN
    localparam int NCH = 3;
    logic [NCH-1:0] raw_in;
    assign raw_in = {gest_r, gest_l, power_btn};
`else
    localparam int NCH = 1;
    logic [NCH-1:0] raw_in;
    logic           unused_gest;
    assign raw_in      = power_btn;
    assign unused_gest = gest_l ^ gest_r ^ (GEST_CYCLES == 0);
`endif

    logic [NCH-1:0] deb_level;
    logic [NCH-1:0] deb_rise;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic             level_d_reg;
            logic [DEB_W-1:0] cnt_reg;

            // Level flips only after DEB_CYCLES consecutive samples that disagree with it.
            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    level_reg   <= 1'b0;
                    level_d_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync1_reg   <= raw_in[gi];
                    sync2_reg   <= sync1_reg;
                    level_d_reg <= level_reg;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign deb_level[gi] = level_reg;
            assign deb_rise[gi]  = level_reg & ~level_d_reg;
        end
    endgenerate

    logic btn_level;
    logic btn_rise;
    assign btn_level = deb_level[0];
    assign btn_rise  = deb_rise[0];

    state_t              state_reg, state_next;
    logic [LONG_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic                power_on_reg, on_pulse_reg, off_pulse_reg;
    logic                gest_on_req, gest_off_req;

`ifdef GESTURE_CTRL_EN
    localparam int GEST_W = $clog2(GEST_CYCLES + 1);
    localparam logic [GEST_W-1:0] GEST_MAX = GEST_W'(GEST_CYCLES);

    logic              win_armed_reg, win_armed_next;
    logic [GEST_W-1:0] win_cnt_reg, win_cnt_next;
    logic              arm_edge, fire_edge;

    // OFF: left arms, right fires. ON: right arms, left fires.
    always_comb begin
        arm_edge  = 1'b0;
        fire_edge = 1'b0;
        if (state_reg == ST_OFF) begin
            arm_edge  = deb_rise[1];
            fire_edge = deb_rise[2];
        end else if (state_reg == ST_ON) begin
            arm_edge  = deb_rise[2];
            fire_edge = deb_rise[1];
        end
    end

    // A pressed button overrides and clears any pending gesture window.
    always_comb begin
        win_armed_next = win_armed_reg;
        win_cnt_next   = win_cnt_reg;
        gest_on_req    = 1'b0;
        gest_off_req   = 1'b0;
        if (btn_level || state_reg == ST_WAIT_REL) begin
            win_armed_next = 1'b0;
            win_cnt_next   = '0;
        end else if (win_armed_reg && fire_edge) begin
            gest_on_req    = (state_reg == ST_OFF);
            gest_off_req   = (state_reg == ST_ON);
            win_armed_next = 1'b0;
            win_cnt_next   = '0;
        end else if (arm_edge) begin
            win_armed_next = 1'b1;
            win_cnt_next   = GEST_W'(1);
        end else if (win_armed_reg) begin
            if (win_cnt_reg == GEST_MAX) begin
                win_armed_next = 1'b0;
                win_cnt_next   = '0;
            end else begin
                win_cnt_next = win_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            win_armed_reg <= 1'b0;
            win_cnt_reg   <= '0;
        end else begin
            win_armed_reg <= win_armed_next;
            win_cnt_reg   <= win_cnt_next;
        end
    end
`else
    assign gest_on_req  = 1'b0;
    assign gest_off_req = 1'b0;
`endif

    // Hold counter only runs while ON with the button down; saturates, clears on release.
    always_comb begin
        hold_cnt_next = '0;
        if (state_reg == ST_ON && btn_level) begin
            hold_cnt_next = (hold_cnt_reg == LONG_MAX) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_OFF: begin
                if (btn_rise || gest_on_req) state_next = ST_ON;
            end
            ST_ON: begin
                if (hold_cnt_next == LONG_MAX) state_next = ST_WAIT_REL;
                else if (gest_off_req)         state_next = ST_OFF;
            end
            ST_WAIT_REL: begin
                if (!btn_level) state_next = ST_OFF;
            end
            default: state_next = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_OFF;
            hold_cnt_reg  <= '0;
            power_on_reg  <= 1'b0;
            on_pulse_reg  <= 1'b0;
            off_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            power_on_reg  <= (state_next == ST_ON);
            on_pulse_reg  <= (state_reg == ST_OFF) && (state_next == ST_ON);
            off_pulse_reg <= (state_reg == ST_ON) && (state_next != ST_ON);
        end
    end

    assign power_on  = power_on_reg;
    assign on_pulse  = on_pulse_reg;
    assign off_pulse = off_pulse_reg;

endmodule

// File: tb/tb_power_ctrl.sv
// Self-checking bench for power_ctrl: pulse times are predicted into queues at stimulus
// time and popped by a negedge monitor whenever the DUT emits a pulse.
module tb_power_ctrl;
    localparam int DEB  = 4;
    localparam int LONG = 20;
    localparam int GEST = 30;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic power_btn = 1'b0;
    logic gest_l    = 1'b0;
    logic gest_r    = 1'b0;
    logic power_on;
    logic on_pulse;
    logic off_pulse;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;
    int exp_on_q[$];
    int exp_off_q[$];
    bit m_on = 1'b0;

    power_ctrl #(
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG),
        .GEST_CYCLES(GEST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .power_btn(power_btn),
        .gest_l   (gest_l),
        .gest_r   (gest_r),
        .power_on (power_on),
        .on_pulse (on_pulse),
        .off_pulse(off_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step(1);
    endtask

    // Raw press of n cycles; sync (2) + debounce (DEB) + one FSM register sets the latency.
    task automatic press(input int n);
        int c;
        power_btn = 1'b1;
        c = cyc;
        $display("press n=%0d start=%0d", n, c);
        if (n >= DEB) begin
            if (!m_on) begin
                exp_on_q.push_back(c + 3 + DEB);
                m_on = 1'b1;
                if (n >= LONG + 1) begin
                    exp_off_q.push_back(c + 3 + DEB + LONG);
                    m_on = 1'b0;
                end
            end else if (n >= LONG) begin
                exp_off_q.push_back(c + 2 + DEB + LONG);
                m_on = 1'b0;
            end
        end
        step(n);
        power_btn = 1'b0;
        step(DEB + 6);
    endtask

    always @(negedge clk) begin
        int e;
        if (!reset) begin
            if (on_pulse && off_pulse) check_eq("pulse_overlap", 1, 0);
            if (on_pulse) begin
                if (exp_on_q.size() == 0) begin
                    check_eq("on_pulse_unexpected", 1, 0);
                end else begin
                    e = exp_on_q.pop_front();
                    $display("on_pulse at cycle %0d, predicted %0d", cyc, e);
                    check_eq("on_pulse_cycle", cyc, e);
                end
            end
            if (off_pulse) begin
                if (exp_off_q.size() == 0) begin
                    check_eq("off_pulse_unexpected", 1, 0);
                end else begin
                    e = exp_off_q.pop_front();
                    $display("off_pulse at cycle %0d, predicted %0d", cyc, e);
                    check_eq("off_pulse_cycle", cyc, e);
                end
            end
        end
    end

    initial begin
        int c;
        int r;
        reset = 1'b1;
        step(3);
        check_eq("reset_power_on", power_on, 0);
        check_eq("reset_on_pulse", on_pulse, 0);
        check_eq("reset_off_pulse", off_pulse, 0);
        reset = 1'b0;
        step(2);

        press(3);
        check_eq("glitch_power_on", power_on, 0);
        press(10);
        check_eq("press_power_on", power_on, 1);
        press(10);
        check_eq("short_press_stays_on", power_on, 1);
        press(40);
        check_eq("long_hold_power_off", power_on, 0);
        press(10);
        check_eq("repress_power_on", power_on, 1);

        // Reset at hold cycle 10; the still-held button then acts as a fresh press.
        power_btn = 1'b1;
        c = cyc;
        $display("hold for reset start=%0d", c);
        wait_until(c + 2 + DEB + 10);
        reset = 1'b1;
        step(1);
        check_eq("reset_mid_hold_power_on", power_on, 0);
        reset = 1'b0;
        r = cyc;
        m_on = 1'b0;
        exp_on_q.push_back(r + 3 + DEB);
        m_on = 1'b1;
        step(LONG);
        power_btn = 1'b0;
        step(DEB + 6);
        check_eq("held_after_reset_power_on", power_on, 1);

`ifdef GESTURE_CTRL_EN
        // ON: right then left 10 cycles later powers off directly.
        gest_r = 1'b1;
        c = cyc;
        $display("gesture r->l gap=10 start=%0d", c);
        step(6);
        gest_r = 1'b0;
        wait_until(c + 10);
        gest_l = 1'b1;
        exp_off_q.push_back(cyc + 3 + DEB);
        m_on = 1'b0;
        step(6);
        gest_l = 1'b0;
        step(DEB + 6);
        check_eq("gest_off_power_on", power_on, 0);

        // OFF: left then right 25 cycles later powers on.
        gest_l = 1'b1;
        c = cyc;
        $display("gesture l->r gap=25 start=%0d", c);
        step(6);
        gest_l = 1'b0;
        wait_until(c + 25);
        gest_r = 1'b1;
        exp_on_q.push_back(cyc + 3 + DEB);
        m_on = 1'b1;
        step(6);
        gest_r = 1'b0;
        step(DEB + 6);
        check_eq("gest_on_25_power_on", power_on, 1);

        gest_r = 1'b1;
        c = cyc;
        $display("gesture r->l gap=10 start=%0d", c);
        step(6);
        gest_r = 1'b0;
        wait_until(c + 10);
        gest_l = 1'b1;
        exp_off_q.push_back(cyc + 3 + DEB);
        m_on = 1'b0;
        step(6);
        gest_l = 1'b0;
        step(DEB + 6);
        check_eq("gest_off_again_power_on", power_on, 0);

        // OFF: right arrives 35 cycles after left, beyond the window.
        gest_l = 1'b1;
        c = cyc;
        $display("gesture l->r gap=35 start=%0d", c);
        step(6);
        gest_l = 1'b0;
        wait_until(c + 35);
        gest_r = 1'b1;
        step(6);
        gest_r = 1'b0;
        step(DEB + 6);
        check_eq("gest_late_stays_off", power_on, 0);
`else
        // Gesture inputs must have no effect in this build.
        gest_r = 1'b1;
        c = cyc;
        $display("gesture r->l gap=10 start=%0d (ignored)", c);
        step(6);
        gest_r = 1'b0;
        wait_until(c + 10);
        gest_l = 1'b1;
        step(6);
        gest_l = 1'b0;
        step(DEB + 6);
        check_eq("gest_ignored_power_on", power_on, 1);
`endif

        step(5);
        check_eq("on_queue_drained", exp_on_q.size(), 0);
        check_eq("off_queue_drained", exp_off_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/power_ctrl.md
POWER_CTRL -- requirements
Module: power_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 200000, meaning consecutive equal samples needed to accept a new debounced button level.
REQ-002 SHALL have parameter LONG_CYCLES, default 300000000, meaning continuous hold cycles that power the unit off.
REQ-003 SHALL have parameter GEST_CYCLES, default 500000000, meaning maximum cycles from the first gesture to the second.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port power_btn, input, 1 bit: raw, asynchronous power button, high = pressed.
REQ-007 SHALL have port gest_l, input, 1 bit: raw left gesture sensor, high = active.
REQ-008 SHALL have port gest_r, input, 1 bit: raw right gesture sensor, high = active.
REQ-009 SHALL have port power_on, output, 1 bit: registered power level consumed by the downstream feature blocks (light, fan, menu).
REQ-010 SHALL have port on_pulse, output, 1 bit: one-cycle pulse on each OFF->ON transition.
REQ-011 SHALL have port off_pulse, output, 1 bit: one-cycle pulse on each ON->OFF transition.

Function
REQ-012 SHALL pass each raw input through a 2-flop synchronizer, then a debouncer; a debounced level changes only after DEB_CYCLES consecutive identical synchronized samples, and the debounce counter clears on any mismatch.
REQ-013 SHALL derive a one-cycle rising-edge event from each debounced signal.
REQ-014 SHALL implement FSM states OFF, ON, WAIT_REL; power_on = 1 exactly in ON.
REQ-015 SHALL in OFF, on a power_btn rising edge in cycle N, enter ON with power_on=1 and on_pulse=1 in cycle N+1.
REQ-016 SHALL in ON, count cycles while debounced power_btn is high; counter saturates at LONG_CYCLES, clears to 0 on release, and ignores short presses.
REQ-017 SHALL in ON, when the hold counter reaches LONG_CYCLES, enter WAIT_REL with power_on=0 and off_pulse=1 in the following cycle.
REQ-018 SHALL in WAIT_REL, ignore all inputs until debounced power_btn is low, then enter OFF; a held button never re-powers the unit.
REQ-019 SHALL size the counters to ceil(log2(param+1)) bits with no wrap-around.
REQ-020 SHALL give the power button priority over gestures when both are active in the same cycle; gesture state clears in that cycle.
REQ-021 SHALL never assert on_pulse and off_pulse in the same cycle.

Reset
REQ-022 SHALL on reset=1 at a clock edge: state=OFF; power_on=0; on_pulse=0; off_pulse=0; all synchronizer, debounce, hold and gesture registers=0.
REQ-023 SHALL handle reset during a long hold by ending in OFF; a button still held after reset is debounced from 0 and then powers the unit on as a fresh press.

Configuration
REQ-024 SHALL, with GESTURE_CTRL_EN defined: in OFF, a gest_l edge arms an L-window; a gest_r edge within GEST_CYCLES enters ON; in ON, a gest_r edge arms an R-window; a gest_l edge within the window enters OFF directly; window expiry or a state change disarms the window.
REQ-025 SHALL, without GESTURE_CTRL_EN: keep the gest_l/gest_r ports, leave them unconnected internally, and instantiate no gesture synchronizers, debouncers or window counters.

Verification (DEB_CYCLES=4, LONG_CYCLES=20, GEST_CYCLES=30)
REQ-026 SHALL cover: power_btn glitch high for 3 cycles -> no state change, power_on stays 0.
REQ-027 SHALL cover: in OFF, press for 10 cycles then release -> power_on=1 and a single on_pulse; a later 10-cycle press leaves power_on=1.
REQ-028 SHALL cover: in ON, hold 40 cycles -> power_on=0 and one off_pulse 20 cycles after the debounced rise; no on_pulse until release plus a new press.
REQ-029 SHALL cover: reset asserted at hold cycle 10 -> power_on=0 on the next edge; hold counter resumes at 0.
REQ-030 SHALL cover, with GESTURE_CTRL_EN: in OFF, gest_l then gest_r 25 cycles later -> ON; gest_l then gest_r 35 cycles later -> stays OFF.
REQ-031 SHALL cover, with GESTURE_CTRL_EN: in ON, gest_r then gest_l 10 cycles later -> OFF with one off_pulse and no WAIT_REL.
